// File: rtl/multicycle_chunk_adder_if.sv
// rtl/multicycle_chunk_adder_if.sv - operand/result bundle for multicycle_chunk_adder
//
// Groups the request handshake, operands and result of the chunked adder.
//   master: drives start, sub, A, B, Carry_in; observes ready, done, Sum, C_out, overflow
//   slave : the adder side (inverse directions)
// NUM_BITS must match the NUM_BITS of the adder instance it connects to.

interface multicycle_chunk_adder_if #(
    parameter int NUM_BITS = 32
);
    logic                start;
    logic                sub;
    logic [NUM_BITS-1:0] A;
    logic [NUM_BITS-1:0] B;
    logic                Carry_in;
    logic                ready;
    logic                done;
    logic [NUM_BITS-1:0] Sum;
    logic                C_out;
    logic                overflow;

    modport master (
        output start, sub, A, B, Carry_in,
        input  ready, done, Sum, C_out, overflow
    );

    modport slave (
        input  start, sub, A, B, Carry_in,
        output ready, done, Sum, C_out, overflow
    );
endinterface

// File: rtl/multicycle_chunk_adder.sv
// rtl/multicycle_chunk_adder.sv - sequential add/subtract, one CHUNK_BITS slice per clock
//
// Adds (or subtracts) two NUM_BITS operands LSB chunk first, keeping the carry
// between chunks in a register so the critical path is a single chunk-wide
// carry chain. Latency from accepted start to done pulse is NUM_CHUNKS+1 cycles.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset; aborts any operation in flight
//   bus   - multicycle_chunk_adder_if.slave:
//             start/ready handshake, sub, A, B, Carry_in (sampled on accept),
//             done (one-cycle pulse), Sum (held until the next done),
//             C_out (carry out, for sub 1 = no borrow), overflow (signed)
//
// Configuration:
//   MULTICYCLE_ADDER_SAT_EN - when defined, a signed overflow saturates Sum to
//   the most positive / most negative value (sign taken from A). Undefined:
//   Sum wraps and overflow is a flag only.

module multicycle_chunk_adder #(
    parameter int NUM_BITS   = 32,
    parameter int CHUNK_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_chunk_adder_if.slave bus
);

    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if ((NUM_BITS % CHUNK_BITS) != 0) begin : g_bad_chunk
        $error("multicycle_chunk_adder: NUM_BITS must be a multiple of CHUNK_BITS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_BITS-1:0] a_reg;
    logic [NUM_BITS-1:0] b_reg;     // already inverted for subtraction
    logic [NUM_BITS-1:0] acc;       // partial result, never exposed on Sum
    logic                carry;

    logic                ready_r;
    logic                done_r;
    logic [NUM_BITS-1:0] sum_r;
    logic                c_out_r;
    logic                ovf_r;

    logic [31:0]           base;
    logic [CHUNK_BITS-1:0] a_chunk;
    logic [CHUNK_BITS-1:0] b_chunk;
    logic [CHUNK_BITS:0]   chunk_sum;
    logic [NUM_BITS-1:0]   sum_full;
    logic [NUM_BITS-1:0]   sum_final;
    logic                  carry_msb;
    logic                  ovf_next;
    logic                  last_chunk;

    always_comb begin
        base       = 32'(cnt) * 32'(CHUNK_BITS);
        a_chunk    = a_reg[base +: CHUNK_BITS];
        b_chunk    = b_reg[base +: CHUNK_BITS];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_BITS{1'b0}}, carry};
        sum_full   = acc;
        sum_full[base +: CHUNK_BITS] = chunk_sum[CHUNK_BITS-1:0];
        // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c_in.
        // Only meaningful on the last chunk, where it drives the overflow check.
        carry_msb  = chunk_sum[CHUNK_BITS-1] ^ a_chunk[CHUNK_BITS-1] ^ b_chunk[CHUNK_BITS-1];
        ovf_next   = carry_msb ^ chunk_sum[CHUNK_BITS];
        last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));
        sum_final  = sum_full;
`ifdef MULTICYCLE_ADDER_SAT_EN
        // On overflow the true result has the sign of A (operands agree in sign).
        if (ovf_next) begin
            sum_final = a_reg[NUM_BITS-1] ? {1'b1, {(NUM_BITS-1){1'b0}}}
                                          : {1'b0, {(NUM_BITS-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_reg   <= bus.A;
                        b_reg   <= bus.sub ? ~bus.B : bus.B;
                        // Subtraction: A + ~B + ~borrow_in.
                        carry   <= bus.sub ^ bus.Carry_in;
                        acc     <= '0;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= chunk_sum[CHUNK_BITS];
                    acc   <= sum_full;
                    if (last_chunk) begin
                        sum_r   <= sum_final;
                        c_out_r <= chunk_sum[CHUNK_BITS];
                        ovf_r   <= ovf_next;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.Sum      = sum_r;
    assign bus.C_out    = c_out_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// tb/tb_multicycle_chunk_adder.sv - directed self-checking bench for multicycle_chunk_adder

module tb_multicycle_chunk_adder;

`ifdef MULTICYCLE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] last_sum;

    multicycle_chunk_adder_if #(.NUM_BITS(32)) bus ();

    multicycle_chunk_adder #(.NUM_BITS(32), .CHUNK_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge (cycle 0). Issues one op and checks
    // hold-during-RUN, latency, results and single-cycle done.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic ci,
                          input logic [31:0] esum, input logic ec, input logic eo);
        int cyc;
        bus.start    = 1'b1;
        bus.sub      = s;
        bus.A        = a;
        bus.B        = b;
        bus.Carry_in = ci;
        next_cycle();
        bus.start = 1'b0;
        cyc = 1;
        @(negedge clk);
        check({tag, "_ready_run"}, {31'd0, bus.ready}, 32'd0);
        check({tag, "_sum_hold"}, bus.Sum, last_sum);
        while (!bus.done && cyc < 20) begin
            next_cycle();
            cyc++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(cyc), 32'd5);
        check({tag, "_sum"}, bus.Sum, esum);
        check({tag, "_cout"}, {31'd0, bus.C_out}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
        check({tag, "_ready_done"}, {31'd0, bus.ready}, 32'd1);
        next_cycle();
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_sum_keep"}, bus.Sum, esum);
        last_sum = esum;
        next_cycle();
    endtask

    initial begin
        int dones;
        n_cmp = 0;
        n_err = 0;
        last_sum = 32'd0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Carry_in = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", bus.Sum, 32'd0);
        check("rst_cout", {31'd0, bus.C_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        next_cycle();

        run_op("add_ff", 1'b0, 32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0,
               SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h1, 1'b0,
               SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("add_negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0,
               SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1);
        run_op("sub_7_5", 1'b1, 32'd7, 32'd5, 1'b0, 32'd2, 1'b1, 1'b0);
        run_op("sub_5_7", 1'b1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_bin", 1'b1, 32'd5, 32'd2, 1'b1, 32'd2, 1'b1, 1'b0);
        run_op("add_cin", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
        run_op("add_xchunk", 1'b0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

        // Ignored starts during RUN, then back-to-back accept in DONE.
        dones = 0;
        for (int c = 0; c <= 11; c++) begin
            bus.start = 1'b0;
            if (c == 0) begin
                bus.start = 1'b1; bus.sub = 1'b0; bus.A = 32'd1; bus.B = 32'd2; bus.Carry_in = 1'b0;
            end else if (c >= 2 && c <= 4) begin
                bus.start = 1'b1; bus.sub = 1'b1; bus.A = 32'hAAAA_AAAA; bus.B = 32'h5555_5555;
                bus.Carry_in = 1'b1;
            end else if (c == 5) begin
                bus.start = 1'b1; bus.sub = 1'b0; bus.A = 32'd10; bus.B = 32'd20; bus.Carry_in = 1'b0;
            end
            @(negedge clk);
            if (bus.done) dones++;
            if (c == 5) begin
                check("b2b_first_sum", bus.Sum, 32'd3);
                check("b2b_first_done", {31'd0, bus.done}, 32'd1);
                check("b2b_ready_done", {31'd0, bus.ready}, 32'd1);
            end
            if (c == 8) check("b2b_hold", bus.Sum, 32'd3);
            if (c == 10) begin
                check("b2b_second_done", {31'd0, bus.done}, 32'd1);
                check("b2b_second_sum", bus.Sum, 32'd30);
            end
            next_cycle();
        end
        check("b2b_done_count", 32'(dones), 32'd2);
        last_sum = 32'd30;

        // Reset mid-operation.
        bus.start = 1'b1; bus.sub = 1'b0; bus.A = 32'hFFFF_FFFF; bus.B = 32'h1; bus.Carry_in = 1'b0;
        next_cycle();
        bus.start = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_sum", bus.Sum, 32'd0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        next_cycle();
        last_sum = 32'd0;
        run_op("after_abort", 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'd7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
